// File: rtl/fft_pkg.sv
// Shared FFT constants, complex sample type and index helpers used by the
// bit-reversal reorder buffer and its surroundings.
package fft_pkg;

    localparam int FFT_N          = 8;
    localparam int FFT_LOG2N      = 3;
    localparam int FFT_DATA_WIDTH = 16;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    // Reverses the low 'width' bits of idx; bits above 'width' come back zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] idx,
                                                input int unsigned width);
        logic [31:0] rev;
        rev = '0;
        for (int unsigned i = 0; i < width; i++) begin
            rev[i] = idx[width-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Valid/ready stream bundle for the reorder buffer: natural-order input side
// and bit-reversed output side with frame markers.
interface fft_bitrev_reorder_if
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
);

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_re;
    logic signed [DATA_WIDTH-1:0] in_im;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_re;
    logic signed [DATA_WIDTH-1:0] out_im;
    logic                         out_first;
    logic                         out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_first, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_first, out_last
    );

endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer ahead of the FFT datapath.
// Optional synchronous flush port enabled by defining FFT_REORDER_FLUSH_EN.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int N_POINTS   = FFT_N
) (
    input  logic                  clk,
    input  logic                  arst_n,
`ifdef FFT_REORDER_FLUSH_EN
    input  logic                  flush_in,
`endif
    fft_bitrev_reorder_if.slave   bus
);

    localparam int LOG2N = $clog2(N_POINTS);

    cplx_t            r_bank [2][N_POINTS];
    logic [LOG2N-1:0] r_wr_idx;
    logic [LOG2N-1:0] r_rd_idx;
    bank_sel_t        r_wr_bank;
    bank_sel_t        r_rd_bank;
    logic [1:0]       r_bank_full;

    logic             w_flush;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [LOG2N-1:0] w_rd_addr;
    cplx_t            w_rd_word;

`ifdef FFT_REORDER_FLUSH_EN
    assign w_flush = flush_in;
`else
    assign w_flush = 1'b0;
`endif

    // Handshake qualifiers come only from registered flags, so out_ready never
    // reaches in_ready combinationally.
    always_comb begin
        w_in_ready  = ~r_bank_full[r_wr_bank];
        w_out_valid = r_bank_full[r_rd_bank];
        w_wr_fire   = bus.in_valid & w_in_ready;
        w_rd_fire   = w_out_valid & bus.out_ready;
        w_wr_last   = (r_wr_idx == LOG2N'(N_POINTS - 1));
        w_rd_last   = (r_rd_idx == LOG2N'(N_POINTS - 1));
        w_rd_addr   = LOG2N'(bit_reverse(32'(r_rd_idx), LOG2N));
        w_rd_word   = r_bank[r_rd_bank][w_rd_addr];
    end

    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = w_out_valid;
        bus.out_re    = DATA_WIDTH'(w_rd_word.re);
        bus.out_im    = DATA_WIDTH'(w_rd_word.im);
        bus.out_first = w_out_valid & (r_rd_idx == '0);
        bus.out_last  = w_out_valid & w_rd_last;
    end

    // Write and read never target the same bank in one cycle (one needs the
    // bank empty, the other full), so their flag updates cannot collide.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < N_POINTS; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_wr_bank   <= BANK0;
            r_rd_bank   <= BANK0;
            r_bank_full <= '0;
        end else if (w_flush) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_wr_bank   <= BANK0;
            r_rd_bank   <= BANK0;
            r_bank_full <= '0;
        end else begin
            if (w_wr_fire) begin
                r_bank[r_wr_bank][r_wr_idx] <= '{re: bus.in_re, im: bus.in_im};
                if (w_wr_last) begin
                    r_wr_idx                 <= '0;
                    r_bank_full[r_wr_bank]   <= 1'b1;
                    r_wr_bank                <= (r_wr_bank == BANK0) ? BANK1 : BANK0;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (w_rd_last) begin
                    r_rd_idx                 <= '0;
                    r_bank_full[r_rd_bank]   <= 1'b0;
                    r_rd_bank                <= (r_rd_bank == BANK0) ? BANK1 : BANK0;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

endmodule
